firebird7_in_gate1_tessent_tdr_w19: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_TDR_W19 -- requirements
Module: firebird7_in_gate1_tessent_tdr_w19

---
 rtl/firebird7_in_gate1_tessent_tdr_w19.sv | 85 ++++++++
 tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// IJTAG test data register: select bit plus WIDTH-bit data field.
// Capture/shift/update on ijtag_tck. A sticky flag records any update that
// followed a shift count other than the chain length.
module firebird7_in_gate1_tessent_tdr_w19 #(
    parameter int unsigned WIDTH        = 19,
    parameter logic        SELECT_RESET = 1'b0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] capture_data_in,
    output logic [WIDTH-1:0] ijtag_data_in,
    output logic             ijtag_select,
    output logic             length_err
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CHAIN_LEN = CNT_W'(WIDTH + 1);

    logic [WIDTH:0]   sr;
    logic [WIDTH:0]   ur;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic capture_en;
    logic shift_en;
    logic update_en;

    // Operation decode; capture takes priority over shift.
    assign capture_en = ijtag_sel & ijtag_ce;
    assign shift_en   = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign update_en  = ijtag_sel & ijtag_ue;

    // Shift register: capture loads current select and observed data, shift moves toward bit 0.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr <= '0;
        end else if (capture_en) begin
            sr <= {ur[WIDTH], capture_data_in};
        end else if (shift_en) begin
            sr <= {ijtag_si, sr[WIDTH:1]};
        end
    end

    // Update register: takes the pre-edge shift register contents, select and data together.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            ur <= {SELECT_RESET, WIDTH'(0)};
        end else if (update_en) begin
            ur <= sr;
        end
    end

    // Saturating shift counter, restarted by capture.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            cnt <= '0;
        end else if (capture_en) begin
            cnt <= '0;
        end else if (shift_en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sticky length error: set by an update after a wrong-length shift.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            err_q <= 1'b0;
        end else if (update_en && (cnt != CHAIN_LEN)) begin
            err_q <= 1'b1;
        end
    end

    assign ijtag_so      = sr[0];
    assign ijtag_select  = ur[WIDTH];
    assign ijtag_data_in = ur[WIDTH-1:0];
    assign length_err    = err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19.sv
// Self-checking bench for the IJTAG TDR: scoreboard queues hold expected
// scan-out bits and expected update-register contents.
module tb_firebird7_in_gate1_tessent_tdr_w19;

    localparam int unsigned WIDTH  = 19;
    localparam logic        SEL_RST = 1'b0;

    logic             ijtag_tck = 1'b0;
    logic             ijtag_reset = 1'b1;
    logic             ijtag_sel = 1'b0;
    logic             ijtag_ce = 1'b0;
    logic             ijtag_se = 1'b0;
    logic             ijtag_ue = 1'b0;
    logic             ijtag_si = 1'b0;
    logic             ijtag_so;
    logic [WIDTH-1:0] capture_data_in = '0;
    logic [WIDTH-1:0] ijtag_data_in;
    logic             ijtag_select;
    logic             length_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             err;
        logic             sel;
        logic [WIDTH-1:0] data;
    } ur_exp_t;

    ur_exp_t ur_q[$];
    logic    so_q[$];

    firebird7_in_gate1_tessent_tdr_w19 #(
        .WIDTH(WIDTH),
        .SELECT_RESET(SEL_RST)
    ) dut (
        .ijtag_tck(ijtag_tck),
        .ijtag_reset(ijtag_reset),
        .ijtag_sel(ijtag_sel),
        .ijtag_ce(ijtag_ce),
        .ijtag_se(ijtag_se),
        .ijtag_ue(ijtag_ue),
        .ijtag_si(ijtag_si),
        .ijtag_so(ijtag_so),
        .capture_data_in(capture_data_in),
        .ijtag_data_in(ijtag_data_in),
        .ijtag_select(ijtag_select),
        .length_err(length_err)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic apply_reset();
        ijtag_reset = 1'b1;
        tick();
        ijtag_reset = 1'b0;
    endtask

    task automatic capture(input logic [WIDTH-1:0] v);
        ijtag_sel       = 1'b1;
        ijtag_ce        = 1'b1;
        capture_data_in = v;
        tick();
        ijtag_ce = 1'b0;
    endtask

    task automatic shift_bits(input logic [WIDTH:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            ijtag_si = p[i];
            ijtag_se = 1'b1;
            tick();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic update();
        ijtag_ue = 1'b1;
        tick();
        ijtag_ue = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ijtag_select !== SEL_RST) begin
            errors++; $display("FAIL reset_select got %b want %b", ijtag_select, SEL_RST);
        end
        checks++;
        if (ijtag_data_in !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", ijtag_data_in);
        end
        checks++;
        if (ijtag_so !== 1'b0) begin
            errors++; $display("FAIL reset_so got %b want 0", ijtag_so);
        end
        checks++;
        if (length_err !== 1'b0) begin
            errors++; $display("FAIL reset_length_err got %b want 0", length_err);
        end
    endtask

    task automatic test_capture_shift();
        logic [WIDTH-1:0] v;
        logic             exp_bit;
        v = 19'h5A5A5;
        apply_reset();
        capture(v);
        for (int i = 0; i < int'(WIDTH); i++) so_q.push_back(v[i]);
        so_q.push_back(SEL_RST);
        for (int i = 0; i <= int'(WIDTH); i++) begin
            exp_bit = so_q.pop_front();
            checks++;
            if (ijtag_so !== exp_bit) begin
                errors++; $display("FAIL capture_so_bit%0d got %b want %b", i, ijtag_so, exp_bit);
            end
            shift_bits(20'h0, 1);
        end
    endtask

    task automatic test_full_update();
        ur_exp_t e;
        apply_reset();
        capture(19'h12345);
        shift_bits(20'hFFFFF, 20);
        ur_q.push_back('{err: 1'b0, sel: 1'b1, data: 19'h7FFFF});
        update();
        e = ur_q.pop_front();
        checks++;
        if (ijtag_select !== e.sel) begin
            errors++; $display("FAIL full_select got %b want %b", ijtag_select, e.sel);
        end
        checks++;
        if (ijtag_data_in !== e.data) begin
            errors++; $display("FAIL full_data got %h want %h", ijtag_data_in, e.data);
        end
        checks++;
        if (length_err !== e.err) begin
            errors++; $display("FAIL full_length_err got %b want %b", length_err, e.err);
        end
    endtask

    task automatic test_length_err();
        ur_exp_t e;
        apply_reset();
        capture(19'h0);
        shift_bits(20'hFFFFF, 19);
        ur_q.push_back('{err: 1'b1, sel: 1'b1, data: 19'h7FFFE});
        update();
        e = ur_q.pop_front();
        checks++;
        if (length_err !== e.err) begin
            errors++; $display("FAIL short_length_err got %b want %b", length_err, e.err);
        end
        checks++;
        if ({ijtag_select, ijtag_data_in} !== {e.sel, e.data}) begin
            errors++; $display("FAIL short_ur got %h want %h", {ijtag_select, ijtag_data_in}, {e.sel, e.data});
        end
        capture(19'h11111);
        shift_bits(20'h2AAAA, 20);
        ur_q.push_back('{err: 1'b1, sel: 1'b0, data: 19'h2AAAA});
        update();
        e = ur_q.pop_front();
        checks++;
        if (length_err !== e.err) begin
            errors++; $display("FAIL sticky_length_err got %b want %b", length_err, e.err);
        end
        checks++;
        if ({ijtag_select, ijtag_data_in} !== {e.sel, e.data}) begin
            errors++; $display("FAIL sticky_ur got %h want %h", {ijtag_select, ijtag_data_in}, {e.sel, e.data});
        end
    endtask

    task automatic test_simultaneous();
        ur_exp_t e;
        logic [WIDTH:0] cap_exp;
        logic           exp_bit;
        apply_reset();
        capture(19'h0);
        shift_bits(20'hABCDE, 20);
        ur_q.push_back('{err: 1'b0, sel: 1'b1, data: 19'h2BCDE});
        ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b1;
        capture_data_in = 19'h13579;
        tick();
        ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
        e = ur_q.pop_front();
        checks++;
        if ({ijtag_select, ijtag_data_in} !== {e.sel, e.data}) begin
            errors++; $display("FAIL simul_ur got %h want %h", {ijtag_select, ijtag_data_in}, {e.sel, e.data});
        end
        checks++;
        if (length_err !== e.err) begin
            errors++; $display("FAIL simul_length_err got %b want %b", length_err, e.err);
        end
        cap_exp = {SEL_RST, 19'h13579};
        for (int i = 0; i <= int'(WIDTH); i++) so_q.push_back(cap_exp[i]);
        for (int i = 0; i <= int'(WIDTH); i++) begin
            exp_bit = so_q.pop_front();
            checks++;
            if (ijtag_so !== exp_bit) begin
                errors++; $display("FAIL simul_so_bit%0d got %b want %b", i, ijtag_so, exp_bit);
            end
            shift_bits(20'h0, 1);
        end
        ur_q.push_back('{err: 1'b0, sel: 1'b0, data: 19'h0});
        update();
        e = ur_q.pop_front();
        checks++;
        if ({length_err, ijtag_select, ijtag_data_in} !== {e.err, e.sel, e.data}) begin
            errors++; $display("FAIL simul_cnt_cleared got %h want %h",
                               {length_err, ijtag_select, ijtag_data_in}, {e.err, e.sel, e.data});
        end
    endtask

    task automatic test_deselect();
        logic [WIDTH:0] p;
        logic           exp_bit;
        p = 20'hC3A5B;
        apply_reset();
        capture(19'h0);
        shift_bits(p, 20);
        update();
        ijtag_sel = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ijtag_ce = 1'($urandom_range(0, 1));
            ijtag_se = 1'($urandom_range(0, 1));
            ijtag_ue = 1'($urandom_range(0, 1));
            ijtag_si = 1'($urandom_range(0, 1));
            capture_data_in = 19'($urandom);
            tick();
            checks++;
            if ({length_err, ijtag_select, ijtag_data_in, ijtag_so} !== {1'b0, p, p[0]}) begin
                errors++; $display("FAIL desel_hold_c%0d got %h want %h", c,
                                   {length_err, ijtag_select, ijtag_data_in, ijtag_so}, {1'b0, p, p[0]});
            end
        end
        ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_si = 1'b0;
        ijtag_sel = 1'b1;
        update();
        checks++;
        if ({length_err, ijtag_select, ijtag_data_in} !== {1'b0, p}) begin
            errors++; $display("FAIL desel_cnt_held got %h want %h",
                               {length_err, ijtag_select, ijtag_data_in}, {1'b0, p});
        end
        for (int i = 0; i <= int'(WIDTH); i++) so_q.push_back(p[i]);
        for (int i = 0; i <= int'(WIDTH); i++) begin
            exp_bit = so_q.pop_front();
            checks++;
            if (ijtag_so !== exp_bit) begin
                errors++; $display("FAIL desel_so_bit%0d got %b want %b", i, ijtag_so, exp_bit);
            end
            shift_bits(20'h0, 1);
        end
    endtask

    task automatic test_reset_mid_shift();
        ur_exp_t e;
        apply_reset();
        capture(19'h7FFFF);
        shift_bits(20'hFFFFF, 10);
        ijtag_reset = 1'b1; ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b1;
        tick();
        ijtag_reset = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
        checks++;
        if ({length_err, ijtag_select, ijtag_data_in, ijtag_so} !== {1'b0, SEL_RST, 19'h0, 1'b0}) begin
            errors++; $display("FAIL midrst_override got %h want %h",
                               {length_err, ijtag_select, ijtag_data_in, ijtag_so}, {1'b0, SEL_RST, 19'h0, 1'b0});
        end
        ur_q.push_back('{err: 1'b1, sel: SEL_RST, data: 19'h0});
        update();
        e = ur_q.pop_front();
        checks++;
        if (ijtag_data_in !== e.data) begin
            errors++; $display("FAIL midrst_data got %h want %h", ijtag_data_in, e.data);
        end
        checks++;
        if (ijtag_select !== e.sel) begin
            errors++; $display("FAIL midrst_select got %b want %b", ijtag_select, e.sel);
        end
        checks++;
        if (length_err !== e.err) begin
            errors++; $display("FAIL midrst_length_err got %b want %b", length_err, e.err);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_capture_shift();
        test_full_update();
        test_length_err();
        test_simultaneous();
        test_deselect();
        test_reset_mid_shift();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
